ram_load_sequencer: RTL

- Top-level load/compute scheduler for the network's shared parameter RAM.
- Walks the step index 1..LAST_STEP and drives it to the step-to-address-range decoder.
- On load steps (decoder re_RAM=1), it bursts RAM reads over [firstaddr, lastaddr). On compute steps, it waits for the datapath's completion pulse.
- Sits between the global GO/done control and the RAM, the address decoder and the conv/dense datapath.

---
 rtl/ram_load_sequencer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/ram_load_sequencer.sv
`timescale 1ns/1ps
// ram_load_sequencer
//
// Walks the network schedule step by step (1..LAST_STEP). Each step index is
// presented to the external step-to-address-range decoder. On load steps
// (re_RAM=1) the sequencer bursts ascending reads over [firstaddr, lastaddr).
// On compute steps it waits for the datapath's compute_done pulse.
//
// Optional build macro: WORD_COUNT_EN adds a words_loaded counter output.
//
// Ports:
//   clk, rst_n     - clock (rising edge), asynchronous active-low reset
//   go             - start pulse, only honoured while idle
//   step           - registered step index to the decoder (0 when idle)
//   re_RAM         - decoder: current step loads from RAM
//   firstaddr      - decoder: first address of the range (inclusive)
//   lastaddr       - decoder: end address of the range (exclusive)
//   stall          - back-pressure; suppresses read issue only
//   compute_done   - datapath pulse: compute step finished
//   ram_addr       - RAM read address
//   ram_re         - RAM read enable
//   data_valid     - read data valid (ram_re delayed RAM_LATENCY cycles)
//   data_last      - with data_valid: final word of the burst
//   busy           - high from go acceptance until the done cycle
//   done           - one-cycle pulse when the whole sequence finishes
//   words_loaded   - (WORD_COUNT_EN only) words received in the current step

module ram_load_sequencer #(
  parameter int ADDR_W      = 13,
  parameter int RAM_LATENCY = 1,
  parameter int LAST_STEP   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  output logic [4:0]        step,
  input  logic              re_RAM,
  input  logic [ADDR_W-1:0] firstaddr,
  input  logic [ADDR_W-1:0] lastaddr,
  input  logic              stall,
  input  logic              compute_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_re,
  output logic              data_valid,
  output logic              data_last,
  output logic              busy,
  output logic              done
`ifdef WORD_COUNT_EN
  ,
  output logic [ADDR_W-1:0] words_loaded
`endif
);

  localparam logic [4:0]        LAST_STEP_V = 5'(LAST_STEP);
  localparam logic [ADDR_W-1:0] ADDR_ONE    = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAP,
    S_BURST,
    S_DRAIN,
    S_COMPUTE,
    S_FINISH
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [4:0]        step_reg;
  logic [ADDR_W-1:0] cur_reg;
  logic [ADDR_W-1:0] end_reg;
  logic [ADDR_W-1:0] hold_reg;     // last issued address, shown while not issuing
  logic              valid_pipe [RAM_LATENCY];
  logic              last_pipe  [RAM_LATENCY];

  logic issue;
  logic issue_last;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (go) state_next = S_MAP;
      end
      S_MAP: begin
        if (!re_RAM) begin
          state_next = S_COMPUTE;
        end else if (firstaddr < lastaddr) begin
          state_next = S_BURST;
        end else begin
          state_next = S_MAP;   // empty range: advance step, re-map
        end
      end
      S_BURST: begin
        if (issue_last) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        // The final word of the burst has come back; nothing in flight.
        if (data_valid && data_last) state_next = S_MAP;
      end
      S_COMPUTE: begin
        if (compute_done) begin
          state_next = (step_reg == LAST_STEP_V) ? S_FINISH : S_MAP;
        end
      end
      S_FINISH: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    issue      = (state_reg == S_BURST) && !stall;
    // cur never reaches end while bursting, so end-1 is the final address.
    issue_last = issue && (cur_reg == (end_reg - ADDR_ONE));
    ram_re     = issue;
    ram_addr   = issue ? cur_reg : hold_reg;
    busy       = (state_reg != S_IDLE);
    done       = (state_reg == S_FINISH);
  end

  // Step index and address counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_reg <= 5'd0;
      cur_reg  <= '0;
      end_reg  <= '0;
      hold_reg <= '0;
    end else begin
      // step only moves on entry to MAP (or back to 0 after FINISH), so the
      // decoder outputs stay stable for the whole step.
      if (state_reg == S_IDLE && state_next == S_MAP) begin
        step_reg <= 5'd1;
      end else if (state_next == S_MAP) begin
        step_reg <= step_reg + 5'd1;
      end else if (state_reg == S_FINISH) begin
        step_reg <= 5'd0;
      end

      if (state_reg == S_MAP) begin
        cur_reg <= firstaddr;
        end_reg <= lastaddr;
      end else if (issue) begin
        cur_reg  <= cur_reg + ADDR_ONE;
        hold_reg <= cur_reg;
      end
    end
  end

  // Read-latency pipeline; free-running so stall never holds data back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RAM_LATENCY; i++) begin
        valid_pipe[i] <= 1'b0;
        last_pipe[i]  <= 1'b0;
      end
    end else begin
      valid_pipe[0] <= issue;
      last_pipe[0]  <= issue_last;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        valid_pipe[i] <= valid_pipe[i-1];
        last_pipe[i]  <= last_pipe[i-1];
      end
    end
  end

  assign step       = step_reg;
  assign data_valid = valid_pipe[RAM_LATENCY-1];
  assign data_last  = last_pipe[RAM_LATENCY-1];

`ifdef WORD_COUNT_EN
  logic [ADDR_W-1:0] words_reg;

  // Cleared during MAP: no read data can be outstanding then because DRAIN
  // waits for the final word, so no arriving word is ever lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_reg <= '0;
    end else if (state_reg == S_MAP) begin
      words_reg <= '0;
    end else if (data_valid) begin
      words_reg <= words_reg + ADDR_ONE;
    end
  end

  assign words_loaded = words_reg;
`endif

endmodule
